// File: rtl/kalman_pkg.sv
// Shared definitions for the Kalman datapath blocks (divider arbiter, matrix inversor).
// Holds the FSM state encoding, the default operand width and the divider Q-format split.
package kalman_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } fsm_state_e;

    localparam int KALMAN_WIDTH = 16;

    // Divider result: integer quotient sits Q_SPLIT operand-widths above bit 0, remainder below.
    localparam int Q_SPLIT = 1;

    function automatic int q_int_lsb(input int width);
        return width * Q_SPLIT;
    endfunction

endpackage

// File: rtl/div_arbiter_rr_priority.sv
// Round-robin one-hot select: scans from last_owner+1 upward (mod NREQ)
// and picks the first requester that is asserting req.
module rr_priority #(
    parameter int NREQ = 4,
    parameter int LW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [LW-1:0]   last_owner,
    output logic [NREQ-1:0] grant,
    output logic [LW-1:0]   grant_idx,
    output logic            any
);

    logic [LW-1:0] cand_s;

    // First asserted requester after last_owner, wrapping once around the ring.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any       = 1'b0;
        cand_s    = '0;
        for (int i = 1; i <= NREQ; i++) begin
            cand_s = LW'((int'(last_owner) + i) % NREQ);
            if (!any && req[cand_s]) begin
                any           = 1'b1;
                grant[cand_s] = 1'b1;
                grant_idx     = cand_s;
            end else begin
                any = any;
            end
        end
    end

endmodule

// File: rtl/div_arbiter.sv
// Shares one external signed divider between NREQ requesters with round-robin
// arbitration, divide-by-zero saturation and a WAIT timeout.
module div_arbiter
    import kalman_pkg::*;
#(
    parameter int WIDTH   = KALMAN_WIDTH,
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] dividend,
    input  logic [NREQ*WIDTH-1:0] divisor,
    output logic [NREQ-1:0]       gnt,
    output logic [NREQ-1:0]       done,
    output logic [WIDTH-1:0]      quotient,
    output logic                  err,
    output logic                  busy,
    output logic [WIDTH-1:0]      div_dividend,
    output logic [WIDTH-1:0]      div_divisor,
    output logic                  div_tvalid,
    input  logic [2*WIDTH-1:0]    div_dout,
    input  logic                  div_dout_valid
);

    localparam int LW   = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW   = $clog2(TIMEOUT + 1);
    localparam int QLSB = q_int_lsb(WIDTH);
    localparam logic [LW-1:0] LAST_RST = LW'(NREQ - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    function automatic logic [WIDTH-1:0] dbz_quotient(input logic negative);
        return negative ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    endfunction

    fsm_state_e       state_r, state_s;
    logic [LW-1:0]    owner_r, owner_s, last_owner_r, last_owner_s, rr_idx_s;
    logic [NREQ-1:0]  rr_grant_s;
    logic             rr_any_s;
    logic [CW-1:0]    cnt_r, cnt_s;
    logic [WIDTH-1:0] win_dividend_s, win_divisor_s;
    logic [WIDTH-1:0] opa_r, opa_s, opb_r, opb_s;
    logic [NREQ-1:0]  gnt_r, gnt_s, done_r, done_s;
    logic [WIDTH-1:0] quotient_r, quotient_s;
    logic             err_r, err_s, busy_r, busy_s, tvalid_r, tvalid_s;
    logic             unused_dout_s;

    rr_priority #(.NREQ(NREQ), .LW(LW)) u_rr (
        .req        (req),
        .last_owner (last_owner_r),
        .grant      (rr_grant_s),
        .grant_idx  (rr_idx_s),
        .any        (rr_any_s)
    );

    assign win_dividend_s = dividend[rr_idx_s*WIDTH +: WIDTH];
    assign win_divisor_s  = divisor[rr_idx_s*WIDTH +: WIDTH];
    assign unused_dout_s  = ^div_dout[QLSB-1:0];

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic; a zero divisor bypasses the divider entirely.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (rr_any_s) state_s = ST_ISSUE;
                else          state_s = ST_IDLE;
            end
            ST_ISSUE: begin
                if (opb_r == '0) state_s = ST_DONE;
                else             state_s = ST_WAIT;
            end
            ST_WAIT: begin
                if (div_dout_valid || (cnt_r == CNT_LAST)) state_s = ST_DONE;
                else                                       state_s = ST_WAIT;
            end
            ST_DONE: state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
    end

    // Output/datapath next values, computed so registered outputs line up with state_s.
    always_comb begin
        gnt_s        = gnt_r;
        done_s       = '0;
        err_s        = 1'b0;
        quotient_s   = quotient_r;
        busy_s       = (state_s != ST_IDLE);
        tvalid_s     = 1'b0;
        cnt_s        = '0;
        opa_s        = opa_r;
        opb_s        = opb_r;
        owner_s      = owner_r;
        last_owner_s = last_owner_r;
        case (state_r)
            ST_IDLE: begin
                if (rr_any_s) begin
                    gnt_s    = rr_grant_s;
                    owner_s  = rr_idx_s;
                    opa_s    = win_dividend_s;
                    opb_s    = win_divisor_s;
                    tvalid_s = (win_divisor_s != '0);
                end else begin
                    gnt_s = '0;
                end
            end
            ST_ISSUE: begin
                if (opb_r == '0) begin
                    done_s     = gnt_r;
                    err_s      = 1'b1;
                    quotient_s = dbz_quotient(opa_r[WIDTH-1]);
                end else begin
                    tvalid_s = 1'b1;
                end
            end
            ST_WAIT: begin
                // A valid on the last counted cycle still wins over the timeout.
                if (div_dout_valid) begin
                    done_s     = gnt_r;
                    quotient_s = div_dout[QLSB +: WIDTH];
                end else if (cnt_r == CNT_LAST) begin
                    done_s     = gnt_r;
                    err_s      = 1'b1;
                    quotient_s = '0;
                end else begin
                    tvalid_s = 1'b1;
                    cnt_s    = cnt_r + CW'(1);
                end
            end
            ST_DONE: begin
                gnt_s        = '0;
                last_owner_s = owner_r;
            end
            default: gnt_s = '0;
        endcase
    end

    // Registered outputs and transaction context.
    always_ff @(posedge clk) begin
        if (rst) begin
            gnt_r        <= '0;
            done_r       <= '0;
            err_r        <= 1'b0;
            busy_r       <= 1'b0;
            tvalid_r     <= 1'b0;
            quotient_r   <= '0;
            cnt_r        <= '0;
            opa_r        <= '0;
            opb_r        <= {{(WIDTH-1){1'b0}}, 1'b1};
            owner_r      <= '0;
            last_owner_r <= LAST_RST;
        end else begin
            gnt_r        <= gnt_s;
            done_r       <= done_s;
            err_r        <= err_s;
            busy_r       <= busy_s;
            tvalid_r     <= tvalid_s;
            quotient_r   <= quotient_s;
            cnt_r        <= cnt_s;
            opa_r        <= opa_s;
            opb_r        <= opb_s;
            owner_r      <= owner_s;
            last_owner_r <= last_owner_s;
        end
    end

    assign gnt          = gnt_r;
    assign done         = done_r;
    assign err          = err_r;
    assign busy         = busy_r;
    assign div_tvalid   = tvalid_r;
    assign quotient     = quotient_r;
    assign div_dividend = opa_r;
    assign div_divisor  = opb_r;

endmodule

// File: tb/tb_div_arbiter.sv
// Self-checking bench for div_arbiter: directed scenarios plus randomized traffic
// checked against a round-robin/arithmetic reference model and a latency-L divider model.
module tb_div_arbiter;

    localparam int W  = 16;
    localparam int N  = 4;
    localparam int TO = 64;

    logic             clk = 1'b0;
    logic             rst;
    logic [N-1:0]     req;
    logic [N*W-1:0]   dividend, divisor;
    logic [N-1:0]     gnt, done;
    logic [W-1:0]     quotient, div_dividend, div_divisor;
    logic             err, busy, div_tvalid;
    logic [2*W-1:0]   div_dout;
    logic             div_dout_valid;

    int checks = 0;
    int errors = 0;
    int model_last = N - 1;
    bit started = 1'b0;

    div_arbiter #(.WIDTH(W), .NREQ(N), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .req(req), .dividend(dividend), .divisor(divisor),
        .gnt(gnt), .done(done), .quotient(quotient), .err(err), .busy(busy),
        .div_dividend(div_dividend), .div_divisor(div_divisor), .div_tvalid(div_tvalid),
        .div_dout(div_dout), .div_dout_valid(div_dout_valid)
    );

    always #5 clk = ~clk;

    // Divider model: result valid L cycles after div_tvalid rises, or never.
    int  div_lat = 4;
    bit  div_never = 1'b0;
    bit  inject_stale = 1'b0;
    bit  tvalid_seen = 1'b0;
    bit  dv_busy = 1'b0;
    int  dv_cnt = 0;
    logic signed [W-1:0] dv_a, dv_b, dv_q, dv_r;

    initial begin
        div_dout = '0;
        div_dout_valid = 1'b0;
    end

    always @(negedge clk) begin
        div_dout_valid = 1'b0;
        if (div_tvalid) tvalid_seen = 1'b1;
        if (inject_stale) begin
            div_dout_valid = 1'b1;
            div_dout = 32'h1234_0000;
            inject_stale = 1'b0;
        end else if (!div_tvalid) begin
            dv_busy = 1'b0;
        end else begin
            if (!dv_busy) begin
                dv_busy = 1'b1;
                dv_cnt = 0;
                dv_a = div_dividend;
                dv_b = div_divisor;
            end else begin
                dv_cnt++;
            end
            if (!div_never && dv_cnt == div_lat) begin
                dv_q = dv_a / dv_b;
                dv_r = dv_a % dv_b;
                div_dout = {dv_q, dv_r};
                div_dout_valid = 1'b1;
            end
        end
    end

    // Structural invariants on every cycle outside reset.
    always @(negedge clk) begin
        if (started && !rst) begin
            checks++;
            if (!$onehot0(gnt) || ((done & ~gnt) != '0) || (err && done == '0) || (!busy && gnt != '0)) begin
                errors++;
                $display("FAIL invariant: gnt=%b done=%b err=%b busy=%b, required one-hot-or-zero gnt covering done, err only with done", gnt, done, err, busy);
            end
        end
    end

    // Reference model helpers.
    function automatic int rr_pick(input logic [N-1:0] m, input int last);
        for (int i = 1; i <= N; i++) begin
            if (m[(last + i) % N]) return (last + i) % N;
        end
        return -1;
    endfunction

    function automatic logic [W-1:0] ref_quot(input int a, input int b, input bit timeout);
        int q;
        if (b == 0) return (a < 0) ? 16'h8000 : 16'h7FFF;
        if (timeout) return '0;
        q = a / b;
        return q[W-1:0];
    endfunction

    task automatic set_ops(input int r, input int a, input int b);
        dividend[r*W +: W] = a[W-1:0];
        divisor[r*W +: W]  = b[W-1:0];
    endtask

    // Waits for a done pulse; lat counts the cycle that sampled req as cycle 1.
    task automatic wait_done(input int budget, output logic [N-1:0] d, output logic [W-1:0] q,
                             output logic e, output logic [N-1:0] g1, output int lat, output bit expired);
        expired = 1'b1; lat = 1; g1 = '0; d = '0; q = '0; e = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            lat++;
            if (i == 0) g1 = gnt;
            if (done != '0) begin
                d = done; q = quotient; e = err; expired = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; req = '0; dividend = '0; divisor = '0;
        repeat (2) @(negedge clk);
        checks += 8;
        if (gnt !== 4'b0000)     begin errors++; $display("FAIL reset_gnt: got %b, want 0000", gnt); end
        if (done !== 4'b0000)    begin errors++; $display("FAIL reset_done: got %b, want 0000", done); end
        if (err !== 1'b0)        begin errors++; $display("FAIL reset_err: got %b, want 0", err); end
        if (busy !== 1'b0)       begin errors++; $display("FAIL reset_busy: got %b, want 0", busy); end
        if (div_tvalid !== 1'b0) begin errors++; $display("FAIL reset_tvalid: got %b, want 0", div_tvalid); end
        if (quotient !== 16'h0)  begin errors++; $display("FAIL reset_quotient: got %h, want 0000", quotient); end
        if (div_dividend !== 16'h0) begin errors++; $display("FAIL reset_div_dividend: got %h, want 0000", div_dividend); end
        if (div_divisor !== 16'h1)  begin errors++; $display("FAIL reset_div_divisor: got %h, want 0001", div_divisor); end
        rst = 1'b0;
        model_last = N - 1;
        started = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single();
        logic [N-1:0] d, g1; logic [W-1:0] q; logic e; int lat; bit ex;
        set_ops(0, 100, 7); div_lat = 4; req = 4'b0001;
        wait_done(20, d, q, e, g1, lat, ex);
        req = '0;
        checks += 6;
        if (ex)              begin errors++; $display("FAIL single_timeout: no done within 20 cycles"); end
        if (g1 !== 4'b0001)  begin errors++; $display("FAIL single_gnt_cycle1: got %b, want 0001", g1); end
        if (d !== 4'b0001)   begin errors++; $display("FAIL single_done: got %b, want 0001", d); end
        if (q !== 16'd14)    begin errors++; $display("FAIL single_quotient: got %0d, want 14", q); end
        if (e !== 1'b0)      begin errors++; $display("FAIL single_err: got %b, want 0", e); end
        if (lat != 7)        begin errors++; $display("FAIL single_latency: got %0d, want 7", lat); end
        model_last = 0;
        @(negedge clk);
        checks += 3;
        if (quotient !== 16'd14) begin errors++; $display("FAIL single_quotient_hold: got %0d, want 14", quotient); end
        if (done !== 4'b0000 || err !== 1'b0) begin errors++; $display("FAIL single_after_done: done=%b err=%b, want 0000/0", done, err); end
        if (busy !== 1'b0)   begin errors++; $display("FAIL single_idle_busy: got %b, want 0", busy); end
    endtask

    task automatic test_zero_div();
        logic [N-1:0] d, g1; logic [W-1:0] q; logic e; int lat; bit ex;
        tvalid_seen = 1'b0;
        set_ops(2, -5, 0); req = 4'b0100;
        wait_done(20, d, q, e, g1, lat, ex);
        req = '0;
        checks += 5;
        if (ex || d !== 4'b0100) begin errors++; $display("FAIL zdiv_done: got %b, want 0100", d); end
        if (q !== 16'h8000)  begin errors++; $display("FAIL zdiv_quotient: got %h, want 8000", q); end
        if (e !== 1'b1)      begin errors++; $display("FAIL zdiv_err: got %b, want 1", e); end
        if (lat != 3)        begin errors++; $display("FAIL zdiv_latency: got %0d, want 3", lat); end
        if (tvalid_seen)     begin errors++; $display("FAIL zdiv_tvalid: got high, want never high"); end
        model_last = 2;
        @(negedge clk);
        set_ops(1, 300, 0); req = 4'b0010;
        wait_done(20, d, q, e, g1, lat, ex);
        req = '0;
        checks += 2;
        if (ex || d !== 4'b0010) begin errors++; $display("FAIL zdiv_pos_done: got %b, want 0010", d); end
        if (q !== 16'h7FFF || e !== 1'b1) begin errors++; $display("FAIL zdiv_pos_result: got %h/%b, want 7fff/1", q, e); end
        model_last = 1;
        @(negedge clk);
    endtask

    task automatic test_timeout();
        logic [N-1:0] d, g1; logic [W-1:0] q; logic e; int lat; bit ex;
        div_never = 1'b1;
        set_ops(3, 50, 5); req = 4'b1000;
        wait_done(TO + 20, d, q, e, g1, lat, ex);
        req = '0;
        div_never = 1'b0;
        checks += 4;
        if (ex || d !== 4'b1000) begin errors++; $display("FAIL timeout_done: got %b, want 1000", d); end
        if (q !== 16'h0)     begin errors++; $display("FAIL timeout_quotient: got %h, want 0000", q); end
        if (e !== 1'b1)      begin errors++; $display("FAIL timeout_err: got %b, want 1", e); end
        if (lat != TO + 3)   begin errors++; $display("FAIL timeout_latency: got %0d, want %0d", lat, TO + 3); end
        model_last = 3;
        @(negedge clk);
    endtask

    task automatic test_contention();
        logic [N-1:0] d, g1; logic [W-1:0] q; logic e; int lat; bit ex;
        int order [5] = '{0, 1, 2, 3, 0};
        rst = 1'b1; @(negedge clk); rst = 1'b0;
        model_last = N - 1;
        for (int r = 0; r < N; r++) set_ops(r, (r + 1) * 100, r + 3);
        div_lat = 2; req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            wait_done(20, d, q, e, g1, lat, ex);
            checks += 2;
            if (ex || d !== (4'b0001 << order[k])) begin errors++; $display("FAIL contention_order[%0d]: got %b, want owner %0d", k, d, order[k]); end
            if (q !== ref_quot((order[k] + 1) * 100, order[k] + 3, 1'b0) || e !== 1'b0) begin
                errors++; $display("FAIL contention_quotient[%0d]: got %0d/%b, want %0d/0", k, q, e, ref_quot((order[k] + 1) * 100, order[k] + 3, 1'b0));
            end
        end
        req = '0;
        model_last = 0;
        @(negedge clk);
    endtask

    task automatic test_req_drop();
        logic [N-1:0] d, g1; logic [W-1:0] q; logic e; int lat; bit ex;
        set_ops(1, -64, 8); div_lat = 5; req = 4'b0010;
        repeat (3) @(negedge clk);
        checks += 1;
        if (busy !== 1'b1 || gnt !== 4'b0010) begin errors++; $display("FAIL drop_midflight: busy=%b gnt=%b, want 1/0010", busy, gnt); end
        req = '0;
        set_ops(1, 1234, 3);
        wait_done(20, d, q, e, g1, lat, ex);
        checks += 2;
        if (ex || d !== 4'b0010) begin errors++; $display("FAIL drop_done: got %b, want 0010", d); end
        if (q !== 16'hFFF8 || e !== 1'b0) begin errors++; $display("FAIL drop_quotient: got %h/%b, want fff8/0", q, e); end
        model_last = 1;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_wait();
        int seen = 0;
        div_never = 1'b1;
        set_ops(2, 77, 7); req = 4'b0100;
        repeat (4) @(negedge clk);
        rst = 1'b1; req = '0;
        @(negedge clk);
        rst = 1'b0;
        checks += 3;
        if (busy !== 1'b0 || gnt !== 4'b0000) begin errors++; $display("FAIL rstwait_state: busy=%b gnt=%b, want 0/0000", busy, gnt); end
        if (div_tvalid !== 1'b0 || div_divisor !== 16'h1) begin errors++; $display("FAIL rstwait_divider: tvalid=%b divisor=%h, want 0/0001", div_tvalid, div_divisor); end
        if (quotient !== 16'h0) begin errors++; $display("FAIL rstwait_quotient: got %h, want 0000", quotient); end
        div_never = 1'b0;
        inject_stale = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (done != '0 || busy) seen++;
        end
        checks += 1;
        if (seen != 0) begin errors++; $display("FAIL rstwait_stale: %0d cycles with done/busy, want 0", seen); end
        model_last = N - 1;
    endtask

    task automatic test_random();
        logic [N-1:0] d, g1, mask; logic [W-1:0] q; logic e; int lat; bit ex;
        int ra [N]; int rb [N]; int w, l;
        for (int t = 0; t < 24; t++) begin
            mask = N'($urandom_range(1, (1 << N) - 1));
            for (int r = 0; r < N; r++) begin
                ra[r] = int'($urandom_range(0, 2000)) - 1000;
                rb[r] = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, 60)) * (($urandom_range(0, 1) == 1) ? -1 : 1);
                set_ops(r, ra[r], rb[r]);
            end
            l = int'($urandom_range(1, 6));
            div_lat = l;
            w = rr_pick(mask, model_last);
            req = mask;
            wait_done(30, d, q, e, g1, lat, ex);
            req = '0;
            checks += 4;
            if (ex || d !== (4'b0001 << w)) begin errors++; $display("FAIL rand[%0d]_owner: got %b, want owner %0d", t, d, w); end
            if (q !== ref_quot(ra[w], rb[w], 1'b0)) begin errors++; $display("FAIL rand[%0d]_quotient: got %h, want %h", t, q, ref_quot(ra[w], rb[w], 1'b0)); end
            if (e !== (rb[w] == 0)) begin errors++; $display("FAIL rand[%0d]_err: got %b, want %b", t, e, rb[w] == 0); end
            if (lat != ((rb[w] == 0) ? 3 : l + 3)) begin errors++; $display("FAIL rand[%0d]_latency: got %0d, want %0d", t, lat, (rb[w] == 0) ? 3 : l + 3); end
            model_last = w;
            @(negedge clk);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; req = '0; dividend = '0; divisor = '0;
        @(negedge clk);
        test_reset();
        test_single();
        test_zero_div();
        test_timeout();
        test_contention();
        test_req_drop();
        test_reset_mid_wait();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/div_arbiter.md
DIV_ARBITER -- requirements
Module: div_arbiter

Interface
REQ-001 Parameters SHALL be: WIDTH, default 16, operand and quotient width; NREQ, default 4, number of requesters; TIMEOUT, default 64, maximum WAIT cycles before abort.
REQ-002 clk  in  1  single clock; all logic SHALL be on its rising edge.
REQ-003 rst  in  1  reset; synchronous, active-high.
REQ-004 req  in  NREQ  per-requester request level.
REQ-005 dividend  in  NREQ x WIDTH  per-requester signed dividend.
REQ-006 divisor  in  NREQ x WIDTH  per-requester signed divisor.
REQ-007 gnt  out  NREQ  one-hot grant, high for the whole transaction of the owner.
REQ-008 done  out  NREQ  one-cycle completion pulse to the owner.
REQ-009 quotient  out  WIDTH  shared result bus; valid only while any done bit is high.
REQ-010 err  out  1  qualifies done: divide-by-zero or timeout.
REQ-011 busy  out  1  high in every state except IDLE.
REQ-012 div_dividend, div_divisor  out  WIDTH each  operands to the external divider.
REQ-013 div_tvalid  out  1  drives both divider input tvalids.
REQ-014 div_dout  in  2*WIDTH  divider result; the integer quotient is [2*WIDTH-1:WIDTH].
REQ-015 div_dout_valid  in  1  divider output valid.

Function
REQ-016 FSM states SHALL be IDLE, ISSUE, WAIT, DONE.
REQ-017 IDLE: if any req bit is high, the arbiter SHALL select a winner by round-robin, starting at (last_owner+1) mod NREQ, then go to ISSUE; otherwise it stays in IDLE.
REQ-018 On the IDLE->ISSUE edge, the winner's dividend and divisor SHALL be latched, and gnt[winner] SHALL rise in ISSUE.
REQ-019 ISSUE (one cycle): div_tvalid=1 with the latched operands, then go to WAIT; divisor==0 instead skips the divider and goes to DONE.
REQ-020 WAIT: div_tvalid=1 with operands held; on div_dout_valid, capture div_dout[2W-1:W] and go to DONE.
REQ-021 WAIT: a cycle counter SHALL count from 0; reaching TIMEOUT-1 without div_dout_valid SHALL go to DONE with err=1 and quotient=0.
REQ-022 Divide-by-zero SHALL return quotient 0x7FFF if the dividend >= 0, else 0x8000, with err=1.
REQ-023 DONE (one cycle): done[owner]=1, gnt[owner]=1, quotient and err valid; last_owner<=owner; next state IDLE.
REQ-024 Latency without contention, from req sampled high to done: 3 + L cycles, where L is the cycles from div_tvalid rise to div_dout_valid. Divide-by-zero latency is 3 cycles.
REQ-025 A requester SHALL hold req and its operands until done. If req is still high after done, it is a new request and is arbitrated normally, so other requesters get the next grant.
REQ-026 If req drops mid-transaction, the transaction SHALL complete and done still pulses.
REQ-027 div_dout_valid in IDLE, ISSUE or DONE SHALL be ignored, because it is stale.
REQ-028 Outside DONE: done=0, err=0, quotient holds its last value. Outside IDLE: gnt is one-hot or zero.

Reset
REQ-029 rst=1 at any cycle SHALL force IDLE, last_owner=NREQ-1, and gnt=0, done=0, err=0, busy=0, div_tvalid=0, quotient=0, counter=0, div_dividend=0, div_divisor=1. This holds mid-transaction: no done is issued for the aborted owner.

Structure
REQ-030 The FSM state enum, WIDTH default, and the Q-format split constant SHALL live in the shared kalman package, reused by the matrix inversor.
REQ-031 One sub-module, rr_priority (NREQ-wide round-robin one-hot select from req and last_owner), SHALL be instantiated. The divider stays external.

Verification
REQ-032 Single request: req[0] with 100/7, divider model L=4 -> gnt[0] from cycle 1, done[0] at cycle 7, quotient=14, err=0.
REQ-033 Contention: req=0b1111 held constantly, last_owner=3 -> grant order 0,1,2,3,0 and no starvation.
REQ-034 Zero divisor: req[2] with -5/0 -> done[2] at cycle 3, quotient=0x8000, err=1, div_tvalid never high.
REQ-035 Timeout: divider model never asserts valid -> done at TIMEOUT+3 cycles, err=1, quotient=0.
REQ-036 Reset mid-WAIT: rst for 1 cycle, then a late div_dout_valid -> no done pulse, state IDLE, busy=0.
REQ-037 Req drop: req[1] falls in WAIT -> done[1] still pulses with the correct quotient (e.g. -64/8 = 0xFFF8).
